apb_master_bridge: RTL

APB initiator (requester) that converts single-outstanding host requests into APB transfers toward up to NUM_SLAVES APB slave interfaces. It sits between the SoC host-side bus adapter and the peripheral register blocks (GPIO, PWM, UART, ...). It provides:
- slave select decode from address bits
- SETUP/ACCESS phase sequencing
- PREADY wait-state handling with a timeout
- PRDATA/PSLVERR return muxing

---
 rtl/apb_master_bridge_if.sv | 31 +++
 rtl/apb_master_bridge.sv | 93 +++++++++
 2 files changed

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: host request/response channel plus the APB bus of the bridge
interface apb_master_bridge_if #(
    parameter int NUM_SLAVES = 4
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [31:0]                  req_addr;
    logic [31:0]                  req_wdata;
    logic                         rsp_valid;
    logic [31:0]                  rsp_rdata;
    logic                         rsp_err;
    logic [31:0]                  PADDR;
    logic [31:0]                  PWDATA;
    logic                         PWRITE;
    logic                         PENABLE;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic [NUM_SLAVES-1:0][31:0]  PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PENABLE, PSEL
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PENABLE, PSEL
    );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding host request to APB transfer bridge with decode and timeout
module apb_master_bridge #(
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 n_rst,
    apb_master_bridge_if.master bus
);
    localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;
    localparam logic [31:0] ERR_DATA = 32'hbad1bad1;

    logic [1:0]       state;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             bad_sel;
    logic             ready_sel;
    logic             timed_out;
    logic             done;
    logic             abort;

    assign sel       = bus.req_addr[SEL_LSB +: SEL_W];
    assign bad_sel   = int'(sel) >= NUM_SLAVES;
    assign accept    = state == IDLE && bus.req_valid;
    assign ready_sel = bus.PREADY[idx];
    // a timeout fires on the ACCESS cycle that would be the TIMEOUT_CYCLES-th consecutive low PREADY
    assign timed_out = TIMEOUT_CYCLES != 0 && state == ACCESS && !ready_sel &&
                       wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign abort     = state == DECERR || timed_out;
    assign done      = state == DECERR || (state == ACCESS && (ready_sel || timed_out));

    assign bus.req_ready = state == IDLE;
    assign bus.PSEL      = (state == SETUP || state == ACCESS) ? NUM_SLAVES'(1) << idx : '0;
    assign bus.PENABLE   = state == ACCESS;

    // phase sequencing: IDLE -> SETUP -> ACCESS -> IDLE, or IDLE -> DECERR -> IDLE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= accept ? (bad_sel ? DECERR : SETUP) :
                     state == SETUP ? ACCESS :
                     done ? IDLE : state;
    end

    // latch the request; APB address/data only move for decodable requests so the bus stays quiet otherwise
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx        <= '0;
            bus.PADDR  <= '0;
            bus.PWDATA <= '0;
            bus.PWRITE <= 1'b0;
        end else if (accept) begin
            idx <= sel;
            if (!bad_sel) begin
                bus.PADDR  <= bus.req_addr;
                bus.PWDATA <= bus.req_wdata;
                bus.PWRITE <= bus.req_write;
            end
        end
    end

    // count consecutive PREADY-low ACCESS cycles, restarting with every accepted request
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            wait_cnt <= '0;
        else
            wait_cnt <= accept ? '0 : (state == ACCESS && !ready_sel) ? wait_cnt + 1'b1 : wait_cnt;
    end

    // registered response: one-cycle valid pulse, data and error held until the next completion
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= done;
            if (done) begin
                bus.rsp_rdata <= abort ? ERR_DATA : bus.PWRITE ? 32'h0 : bus.PRDATA[idx];
                bus.rsp_err   <= abort || bus.PSLVERR[idx];
            end
        end
    end
endmodule
